// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the display-link SPI master
package spi_pkg;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned CLKDIV_DEFAULT = 4;
  localparam int unsigned GAP_DEFAULT    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_STALL,
    ST_TAIL,
    ST_GAP
  } spi_state_e;
endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - restartable half-period counter for the SPI master
// tick_o marks the last clk of a half-period; pre_tick_o the one before it.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int unsigned CLKDIV = CLKDIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o,
  output logic pre_tick_o
);
  logic [7:0] cnt_q, cnt_d;

  assign tick_o     = (cnt_q == 8'(CLKDIV - 1));
  assign pre_tick_o = (cnt_q == 8'(CLKDIV - 2));

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (restart_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - byte-stream SPI master with active-high frame select
// Frames are byte sequences ended by last; ss stays high across back-to-back bytes.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLKDIV = CLKDIV_DEFAULT,
  parameter int unsigned GAP    = GAP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] data,
  input  logic              valid,
  input  logic              last,
  output logic              ready,
  output logic              sclk,
  output logic              ss,
  output logic              mosi,
  output logic              busy,
  output logic              done
);
  spi_state_e        state_q, state_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        gap_q, gap_d;
  logic              last_q, last_d;
  logic              sclk_q, sclk_d;
  logic              ss_q, ss_d;
  logic              mosi_q, mosi_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick, pre_tick, restart, accept, bit0_end;

  assign accept   = valid && ready_q;
  assign bit0_end = (state_q == ST_SHIFT) && sclk_q && (bit_q == 3'd0) && tick;
  assign restart  = (state_d != state_q);

  spi_clk_div #(.CLKDIV(CLKDIV)) u_clk_div (
    .clk        (clk),
    .rst        (rst),
    .restart_i  (restart),
    .tick_o     (tick),
    .pre_tick_o (pre_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_LOAD;
      ST_LOAD:  if (tick) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (bit0_end) begin
          if (last_q)      state_d = ST_TAIL;
          else if (accept) state_d = ST_SHIFT;
          else             state_d = ST_STALL;
        end
      end
      ST_STALL: if (accept) state_d = ST_LOAD;
      ST_TAIL:  if (tick) state_d = ST_GAP;
      ST_GAP:   if (gap_q == 8'(GAP - 1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sclk_d  = sclk_q;
    ss_d    = ss_q;
    mosi_d  = mosi_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    last_d  = last_q;
    gap_d   = '0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) ss_d = 1'b1;
      ST_LOAD: if (tick) sclk_d = 1'b1;
      ST_SHIFT: begin
        if (tick) begin
          sclk_d = !sclk_q;
          if (sclk_q && (bit_q != 3'd0)) begin
            bit_d  = bit_q - 3'd1;
            mosi_d = shreg_q[bit_q - 3'd1];
          end
        end
      end
      ST_TAIL: begin
        if (tick) begin
          ss_d   = 1'b0;
          done_d = 1'b1;
        end
      end
      ST_GAP:  gap_d = gap_q + 8'd1;
      default: ;
    endcase
    // A mid-frame accept lands on the bit0 falling edge, so new bit7 leads the low half.
    if (accept) begin
      shreg_d = data;
      last_d  = last;
      mosi_d  = data[BYTE_W-1];
      bit_d   = 3'd7;
    end
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE) || (state_d == ST_STALL) ||
              ((state_q == ST_SHIFT) && sclk_q && (bit_q == 3'd0) && !last_q && pre_tick);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      last_q  <= 1'b0;
      sclk_q  <= 1'b0;
      ss_q    <= 1'b0;
      mosi_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      sclk_q  <= sclk_d;
      ss_q    <= ss_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign sclk  = sclk_q;
  assign ss    = ss_q;
  assign mosi  = mosi_q;
  assign busy  = busy_q;
  assign done  = done_q;
endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - randomized self-checking bench for spi_master
// Expected waveforms come from a per-frame timeline built from accept cycles.
module tb_spi_master;
  localparam int C = 4;
  localparam int G = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       last = 1'b0;
  logic       ready, sclk, ss, mosi, busy, done;

  spi_master #(.CLKDIV(C), .GAP(G)) dut (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .valid (valid),
    .last  (last),
    .ready (ready),
    .sclk  (sclk),
    .ss    (ss),
    .mosi  (mosi),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Current frame: accept cycle of every byte and the first idle cycle after GAP.
  int         acc[16];
  int         dly[16];
  logic [7:0] fb[16];
  int         nb = 0;
  int         a0 = 0;
  int         t_end = 0;
  bit         have_rec = 1'b0;
  bit         mon_en = 1'b0;

  function automatic void model_at(input int c, output logic e_sclk, output logic e_ss,
                                   output logic e_ready, output logic e_busy,
                                   output logic e_done, output int e_mosi);
    int al;
    int s;
    e_sclk = 1'b0; e_ss = 1'b0; e_ready = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_mosi = -1;
    if (!have_rec || c <= a0 || c >= t_end) return;
    al      = acc[nb-1];
    e_ready = 1'b0;
    e_busy  = 1'b1;
    e_ss    = (c <= al + 17*C);
    e_done  = (c == al + 17*C + 1);
    for (int j = 0; j < nb; j++) begin
      for (int k = 0; k < 8; k++) begin
        s = acc[j] + 1 + C + 2*C*(7-k);
        if (c >= s && c < s + C) begin
          e_sclk = 1'b1;
          e_mosi = int'(fb[j][k]);
        end
      end
      if (j < nb-1 && c >= acc[j] + 16*C && c <= acc[j+1]) e_ready = 1'b1;
    end
  endfunction

  always @(negedge clk) begin : monitor
    logic es, ess, er, eb, ed;
    int   em;
    if (mon_en && !rst) begin
      model_at(cyc, es, ess, er, eb, ed, em);
      check_eq("sclk", sclk, es);
      check_eq("ss", ss, ess);
      check_eq("ready", ready, er);
      check_eq("busy", busy, eb);
      check_eq("done", done, ed);
      if (em >= 0) check_eq("mosi", mosi, em[0]);
    end
  end

  // Receiver: synchronous edge detector sampling mosi on each sclk rise while ss is high.
  logic [7:0] rx_sh = 8'h00;
  int         rx_n = 0;
  logic       sclk_prev = 1'b0;
  int         rises = 0;
  int         ss_cycles = 0;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (rst || !ss) begin
      rx_n = 0;
    end else if (sclk && !sclk_prev) begin
      rx_sh = {rx_sh[6:0], mosi};
      rx_n++;
      rises++;
      if (rx_n == 8) begin
        rx_q.push_back(rx_sh);
        rx_n = 0;
      end
    end
    if (ss) ss_cycles++;
    sclk_prev = sclk;
  end

  // Call in a cycle where the block is idle; fb/dly must already hold the frame.
  task automatic run_frame(input int n, input bit early, input bit keep_valid);
    a0     = cyc;
    acc[0] = cyc;
    for (int j = 1; j < n; j++) acc[j] = acc[j-1] + 16*C + (early ? 0 : dly[j]);
    nb       = n;
    t_end    = acc[n-1] + 17*C + G + 1;
    have_rec = 1'b1;
    rises     = 0;
    ss_cycles = 0;
    rx_q.delete();
    for (int j = 0; j < n; j++) begin
      if (j == 0 || early) begin
        valid = 1'b1; data = fb[j]; last = (j == n-1);
      end else begin
        valid = 1'b0; data = 8'($urandom); last = 1'($urandom_range(0, 1));
      end
      while (cyc < acc[j]) step();
      valid = 1'b1; data = fb[j]; last = (j == n-1);
      step();
    end
    if (keep_valid) begin
      valid = 1'b1; data = 8'($urandom); last = 1'b1;
    end else begin
      valid = 1'b0;
    end
    while (cyc < t_end) step();
    check_eq("rises", rises, 8*n);
    check_eq("ss_len", ss_cycles, acc[n-1] - a0 + 17*C);
    check_eq("rx_cnt", rx_q.size(), n);
    for (int j = 0; j < n; j++)
      if (j < rx_q.size()) check_eq("rx_byte", rx_q[j], fb[j]);
  endtask

  task automatic release_reset();
    rst = 1'b0;
    step();
    check_eq("ready_after_rst", ready, 1'b1);
    mon_en = 1'b1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a_r;
    repeat (3) step();
    check_eq("rst_ready", ready, 1'b0);
    check_eq("rst_ss", ss, 1'b0);
    check_eq("rst_sclk", sclk, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    release_reset();
    step();

    fb[0] = 8'hA5;
    run_frame(1, 1'b0, 1'b0);
    step();

    fb[0] = 8'h3C; fb[1] = 8'hFF; fb[2] = 8'h00;
    run_frame(3, 1'b1, 1'b0);

    fb[0] = 8'h5A; fb[1] = 8'h96; dly[1] = 10;
    run_frame(2, 1'b0, 1'b0);

    fb[0] = 8'h11;
    run_frame(1, 1'b0, 1'b1);
    fb[0] = 8'h22;
    run_frame(1, 1'b0, 1'b0);
    step();

    // Reset on the 4th sclk rise of a frame, then a clean frame.
    mon_en = 1'b0; have_rec = 1'b0;
    a_r = cyc;
    valid = 1'b1; data = 8'hC3; last = 1'b1;
    step();
    valid = 1'b0;
    while (cyc < a_r + 1 + 7*C) step();
    check_eq("pre_rst_sclk", sclk, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("midrst_ss", ss, 1'b0);
    check_eq("midrst_sclk", sclk, 1'b0);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_done", done, 1'b0);
    check_eq("midrst_mosi", mosi, 1'b0);
    step();
    check_eq("midrst_ready", ready, 1'b0);
    release_reset();
    repeat (4) step();
    fb[0] = 8'h81;
    run_frame(1, 1'b0, 1'b0);

    for (int f = 0; f < 24; f++) begin
      int n;
      bit early, keep;
      n     = $urandom_range(1, 4);
      early = ($urandom_range(0, 2) == 0);
      keep  = (f < 23) && ($urandom_range(0, 3) == 0);
      for (int j = 0; j < n; j++) begin
        fb[j]  = 8'($urandom);
        dly[j] = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 12);
      end
      run_frame(n, early, keep);
      if (!keep) repeat ($urandom_range(0, 3)) step();
    end
    valid = 1'b0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
